cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit result ports.
REQ-002 Parameter FIFO_DEPTH, default 2: entries per FU result queue; power of two, at least 2.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous active-low reset; asserted when 0.
REQ-005 squash_signal  input  1  synchronous flush of all held results.
REQ-006 fu_valid  input  NUM_FU  bit i high: fu_packet[i] carries a completed result.
REQ-007 fu_packet  input  NUM_FU x CDB_PACKET  per-FU result: Tag, Value, alu_result, PC, NPC, inst, take_branch, halt, illegal, valid.
REQ-008 fu_ready  output  NUM_FU  bit i high: queue i accepts a result this cycle.
REQ-009 CDB_packet_out  output  CDB_PACKET  registered broadcast to ROB and RS; .valid marks a live broadcast.
REQ-010 pending  output  1  high when any queue is non-empty.

Function
REQ-011 Each FU has a private FIFO of FIFO_DEPTH CDB_PACKET entries, with wrap-around read/write pointers and an occupancy count of $clog2(FIFO_DEPTH)+1 bits.
REQ-012 fu_ready[i] = (count[i] != FIFO_DEPTH); it is derived from registered state only and never depends on fu_valid or on the current grant.
REQ-013 Push i occurs at a rising edge when fu_valid[i] && fu_ready[i]; fu_packet[i] is stored unmodified.
REQ-014 When a queue is full, fu_valid is ignored and the packet is not stored; an FU holds its packet until it sees ready.
REQ-015 Each cycle, at most one non-empty queue is granted, by round-robin: search starts at index rr_ptr and wraps modulo NUM_FU.
REQ-016 On a grant to queue g, the head of queue g is popped and rr_ptr becomes (g+1) mod NUM_FU at the same edge; with no grant, rr_ptr is unchanged.
REQ-017 CDB_packet_out is registered: at the edge that pops queue g, it loads queue g's head with .valid=1.
REQ-018 At an edge with no grant, CDB_packet_out.valid is set to 0; the other CDB_packet_out fields are don't-care.
REQ-019 Latency: a packet pushed at edge k may appear on CDB_packet_out no earlier than after edge k+1; there is no input-to-output bypass.
REQ-020 Push and pop on the same queue in the same edge: count is unchanged and both pointers advance. This is legal only when count < FIFO_DEPTH before the edge, because ready is computed pre-pop.
REQ-021 Packets from one FU broadcast in push order; across FUs, order follows the grant sequence.
REQ-022 Starvation bound: a non-empty queue is granted within NUM_FU cycles.
REQ-023 squash_signal high at an edge has priority over push and pop at that edge, and produces:
  - all counts and pointers = 0;
  - rr_ptr = 0;
  - CDB_packet_out.valid = 0;
  - fu_packet inputs presented that cycle are dropped.
REQ-024 pending = OR over i of (count[i] != 0), from registered state.
REQ-025 The block never alters Tag, Value, or branch fields; matching against ROB PC is the consumer's job.

Reset
REQ-026 While reset=0, asynchronously:
  - all counts, pointers, and rr_ptr = 0;
  - CDB_packet_out = all zeros (valid=0);
  - fu_ready = all ones;
  - pending = 0.
REQ-027 Reset asserted mid-operation discards all queued results; nothing is broadcast until new pushes occur after reset is released.
REQ-028 The first rising edge after reset goes to 1 is a normal functional edge.

Verification
REQ-029 Single result: fu_valid=4'b0010, Tag=5, Value=0x1234 pushed at edge 1 -> CDB_packet_out.valid=1, Tag=5, Value=0x1234 after edge 2; valid=0 after edge 3.
REQ-030 Contention: all four FUs push at edge 1, Tags 1-4 -> broadcasts after edges 2, 3, 4, 5 carry Tags 1, 2, 3, 4; pending=0 after edge 5.
REQ-031 Backpressure: FU0 pushes every cycle while only FU0 is active -> fu_ready[0] never drops, since each edge pushes one and pops one. Then hold FU1 granted continuously and fill FU0 -> fu_ready[0]=0 after 2 unpopped pushes; FU0 entries keep order.
REQ-032 Fairness: FU0 and FU3 both kept non-empty -> grants alternate 0, 3, 0, 3; no queue waits more than 4 cycles.
REQ-033 Squash: 3 entries queued, squash_signal=1 at edge n -> valid=0, pending=0, and fu_ready=4'b1111 after edge n; a push coincident with squash is not broadcast.
REQ-034 Async reset: drive reset=0 between edges while valid=1 -> CDB_packet_out.valid falls immediately, before the next edge; after release, no stale broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Collects completed results from NUM_FU functional units and broadcasts at
//   most one per cycle on the common data bus.
//
//   Each FU has a private FIFO of FIFO_DEPTH packets. A round-robin arbiter
//   picks one non-empty FIFO per cycle. The head of that FIFO is loaded into
//   the registered CDB output, and the round-robin pointer then moves past
//   the winner. No input reaches the output in the same cycle.
//
// Ports
//   clock           rising-edge clock for all state
//   reset           asynchronous active-low reset
//   squash_signal   synchronous flush of every queued result; wins over push/pop
//   fu_valid        per-FU "fu_packet[i] holds a completed result"
//   fu_packet       per-FU result packet, stored unmodified
//   fu_ready        per-FU "queue i accepts a result this cycle" (registered state only)
//   CDB_packet_out  registered broadcast; .valid marks a live broadcast
//   pending         high while any queue holds a result

typedef struct packed {
  logic [4:0]  Tag;
  logic [31:0] Value;
  logic [31:0] alu_result;
  logic [31:0] PC;
  logic [31:0] NPC;
  logic [31:0] inst;
  logic        take_branch;
  logic        halt;
  logic        illegal;
  logic        valid;
} CDB_PACKET;

module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int FIFO_DEPTH = 2   // power of two, at least 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash_signal,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  CDB_PACKET [NUM_FU-1:0]  fu_packet,
  output logic [NUM_FU-1:0]       fu_ready,
  output CDB_PACKET               CDB_packet_out,
  output logic                    pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic [NUM_FU-1:0] not_empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  CDB_PACKET         head_pkt [NUM_FU];

  logic [IW-1:0]     rr_ptr_reg;
  logic [IW-1:0]     rr_ptr_next;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;

  CDB_PACKET         cdb_reg;
  CDB_PACKET         cdb_next;

  // ---------------------------------------------------------------------------
  // Per-FU result queues
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
      CDB_PACKET       mem_reg [FIFO_DEPTH];
      logic [PW-1:0]   wr_ptr_reg;
      logic [PW-1:0]   rd_ptr_reg;
      logic [CW-1:0]   count_reg;

      // Ready looks only at the registered count. A full queue therefore
      // refuses a push even when it is being popped at the same edge.
      assign fu_ready[gi]  = (count_reg != FULL_COUNT);
      assign not_empty[gi] = (count_reg != '0);
      assign push[gi]      = fu_valid[gi] && fu_ready[gi];
      assign pop[gi]       = grant_valid && (grant_idx == IW'(gi));
      assign head_pkt[gi]  = mem_reg[rd_ptr_reg];

      // The storage array has no reset. Stale contents are unreachable
      // once the pointers and count return to zero.
      always_ff @(posedge clock) begin
        if (push[gi] && !squash_signal) begin
          mem_reg[wr_ptr_reg] <= fu_packet[gi];
        end
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else if (squash_signal) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          // The depth is a power of two, so the pointers wrap on overflow.
          if (push[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
          end
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Round-robin grant: the first non-empty queue at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 0; off < NUM_FU; off++) begin
      cand = int'(rr_ptr_reg) + off;
      if (cand >= NUM_FU) begin
        cand = cand - NUM_FU;
      end
      if (!grant_valid && not_empty[IW'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  // The pointer moves just past the winner. A queue that stays non-empty
  // is therefore reached again within NUM_FU grants.
  always_comb begin
    int nxt;
    nxt = int'(grant_idx) + 1;
    if (nxt >= NUM_FU) begin
      nxt = 0;
    end
    rr_ptr_next = grant_valid ? IW'(nxt) : rr_ptr_reg;
  end

  // ---------------------------------------------------------------------------
  // Broadcast register
  // ---------------------------------------------------------------------------
  always_comb begin
    cdb_next       = cdb_reg;
    cdb_next.valid = 1'b0;
    if (grant_valid) begin
      cdb_next       = head_pkt[grant_idx];
      cdb_next.valid = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_reg <= '0;
      cdb_reg    <= '0;
    end else if (squash_signal) begin
      rr_ptr_reg <= '0;
      cdb_reg    <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      cdb_reg    <= cdb_next;
    end
  end

  assign CDB_packet_out = cdb_reg;
  assign pending        = |not_empty;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Self-checking bench for cdb_arbiter (NUM_FU=4, FIFO_DEPTH=2).
//   Part 1 is a cycle table that pairs stimulus with hand-derived outputs.
//   Part 2 uses scoreboard queues for the single-FU streaming case and the
//   two-FU fairness case.
//   Part 3 checks an asynchronous reset applied between clock edges.

module tb_cdb_arbiter;

  localparam int NUM_FU     = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int NROWS      = 20;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   squash_signal;
  logic [NUM_FU-1:0]      fu_valid;
  CDB_PACKET [NUM_FU-1:0] fu_packet;
  logic [NUM_FU-1:0]      fu_ready;
  CDB_PACKET              CDB_packet_out;
  logic                   pending;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cdb_arbiter #(
    .NUM_FU     (NUM_FU),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .squash_signal  (squash_signal),
    .fu_valid       (fu_valid),
    .fu_packet      (fu_packet),
    .fu_ready       (fu_ready),
    .CDB_packet_out (CDB_packet_out),
    .pending        (pending)
  );

  // The packet an FU presents for a given tag. Tag 5 carries Value 0x1234.
  function automatic CDB_PACKET mk_pkt(input logic [4:0] tag);
    CDB_PACKET p;
    p.Tag         = tag;
    p.Value       = 32'h0000_122F + {27'd0, tag};
    p.alu_result  = ~p.Value;
    p.PC          = 32'h0000_0400 + {25'd0, tag, 2'b00};
    p.NPC         = p.PC + 32'd4;
    p.inst        = {tag, 27'h0ABCDEF};
    p.take_branch = tag[0];
    p.halt        = tag[2];
    p.illegal     = tag[1];
    p.valid       = 1'b0;
    return p;
  endfunction

  // The packet expected on the bus: the same fields with valid set.
  function automatic CDB_PACKET bcast(input logic [4:0] tag);
    CDB_PACKET p;
    p       = mk_pkt(tag);
    p.valid = 1'b1;
    return p;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Cycle table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]      vld;
    logic            sq;
    logic [3:0][4:0] tag;
    logic            exp_v;
    logic [4:0]      exp_tag;
    logic [3:0]      exp_rdy;
    logic            exp_pend;
  } vec_t;

  vec_t tbl [NROWS];

  function automatic vec_t v(input logic [3:0] vld, input logic sq,
                             input logic [4:0] t3, input logic [4:0] t2,
                             input logic [4:0] t1, input logic [4:0] t0,
                             input logic ev, input logic [4:0] et,
                             input logic [3:0] er, input logic ep);
    vec_t r;
    r.vld      = vld;
    r.sq       = sq;
    r.tag      = {t3, t2, t1, t0};
    r.exp_v    = ev;
    r.exp_tag  = et;
    r.exp_rdy  = er;
    r.exp_pend = ep;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  CDB_PACKET exp_q0[$];
  CDB_PACKET exp_q3[$];
  bit        fair_mode = 1'b0;
  int        last_fu   = -1;
  int        wait0     = 0;
  int        wait3     = 0;
  int        max_wait  = 0;

  task automatic observe();
    int f;
    f = -1;
    if (CDB_packet_out.valid === 1'b1) begin
      f = int'(CDB_packet_out.Tag[4:3]);
      $display("bcast fu=%0d tag=%0d value=%h", f, CDB_packet_out.Tag, CDB_packet_out.Value);
      if (f == 0 && exp_q0.size() > 0) begin
        check("sb fu0 packet", CDB_packet_out, exp_q0.pop_front());
      end else if (f == 3 && exp_q3.size() > 0) begin
        check("sb fu3 packet", CDB_packet_out, exp_q3.pop_front());
      end else begin
        checks++;
        errors++;
        $display("FAIL sb unexpected broadcast: got tag %0d expected none", CDB_packet_out.Tag);
      end
      if (fair_mode) begin
        if (last_fu < 0) check("fair first grant", f, 0);
        else             check("fair alternation", (f != last_fu), 1'b1);
        last_fu = f;
      end
    end
    if (fair_mode) begin
      if (exp_q0.size() > 0 && f != 0) wait0++; else wait0 = 0;
      if (exp_q3.size() > 0 && f != 3) wait3++; else wait3 = 0;
      if (wait0 > max_wait) max_wait = wait0;
      if (wait3 > max_wait) max_wait = wait3;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: vld sq | tags FU3..FU0 | exp valid, exp tag, exp ready, exp pending.
    // Single result.
    tbl[0]  = v(4'b0010, 0,  0,  0,  5,  0,  0,  0, 4'hF, 1);
    tbl[1]  = v(4'b0000, 0,  0,  0,  0,  0,  1,  5, 4'hF, 0);
    tbl[2]  = v(4'b0000, 0,  0,  0,  0,  0,  0,  0, 4'hF, 0);
    // Squash with empty queues clears rr_ptr to 0.
    tbl[3]  = v(4'b0000, 1,  0,  0,  0,  0,  0,  0, 4'hF, 0);
    // Contention: all four FUs push at once.
    tbl[4]  = v(4'b1111, 0,  4,  3,  2,  1,  0,  0, 4'hF, 1);
    tbl[5]  = v(4'b0000, 0,  0,  0,  0,  0,  1,  1, 4'hF, 1);
    tbl[6]  = v(4'b0000, 0,  0,  0,  0,  0,  1,  2, 4'hF, 1);
    tbl[7]  = v(4'b0000, 0,  0,  0,  0,  0,  1,  3, 4'hF, 1);
    tbl[8]  = v(4'b0000, 0,  0,  0,  0,  0,  1,  4, 4'hF, 0);
    tbl[9]  = v(4'b0000, 0,  0,  0,  0,  0,  0,  0, 4'hF, 0);
    // Squash with three entries queued and a coincident push.
    tbl[10] = v(4'b0111, 0,  0,  9,  8,  7,  0,  0, 4'hF, 1);
    tbl[11] = v(4'b1000, 1, 10,  0,  0,  0,  0,  0, 4'hF, 0);
    tbl[12] = v(4'b0000, 0,  0,  0,  0,  0,  0,  0, 4'hF, 0);
    // Backpressure: FU0 fills while FU1 competes; a push to a full queue is dropped.
    tbl[13] = v(4'b0011, 0,  0,  0, 12, 11,  0,  0, 4'hF,    1);
    tbl[14] = v(4'b0011, 0,  0,  0, 14, 13,  1, 11, 4'b1101, 1);
    tbl[15] = v(4'b0001, 0,  0,  0,  0, 15,  1, 12, 4'b1110, 1);
    tbl[16] = v(4'b0001, 0,  0,  0,  0, 16,  1, 13, 4'hF,    1);
    tbl[17] = v(4'b0000, 0,  0,  0,  0,  0,  1, 14, 4'hF,    1);
    tbl[18] = v(4'b0000, 0,  0,  0,  0,  0,  1, 15, 4'hF,    0);
    tbl[19] = v(4'b0000, 0,  0,  0,  0,  0,  0,  0, 4'hF,    0);

    reset         = 1'b0;
    squash_signal = 1'b0;
    fu_valid      = '0;
    for (int i = 0; i < NUM_FU; i++) fu_packet[i] = '0;

    #2;
    check("reset cdb zero", CDB_packet_out, '0);
    check("reset ready",    fu_ready, 4'hF);
    check("reset pending",  pending, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // ---- table-driven part ----
    for (int r = 0; r < NROWS; r++) begin
      fu_valid      = tbl[r].vld;
      squash_signal = tbl[r].sq;
      for (int i = 0; i < NUM_FU; i++) fu_packet[i] = mk_pkt(tbl[r].tag[i]);
      tick();
      fu_valid      = '0;
      squash_signal = 1'b0;
      $display("row %0d vld=%b sq=%b -> valid=%b tag=%0d ready=%b pending=%b",
               r, tbl[r].vld, tbl[r].sq, CDB_packet_out.valid, CDB_packet_out.Tag,
               fu_ready, pending);
      check($sformatf("row%0d valid", r), CDB_packet_out.valid, tbl[r].exp_v);
      if (tbl[r].exp_v) begin
        check($sformatf("row%0d packet", r), CDB_packet_out, bcast(tbl[r].exp_tag));
      end
      check($sformatf("row%0d ready", r), fu_ready, tbl[r].exp_rdy);
      check($sformatf("row%0d pending", r), pending, tbl[r].exp_pend);
    end

    // ---- FU0 streaming alone: one push and one pop per edge, never full ----
    for (int k = 0; k < 8; k++) begin
      check($sformatf("solo ready0 c%0d", k), fu_ready[0], 1'b1);
      fu_valid     = 4'b0001;
      fu_packet[0] = mk_pkt({2'b00, 3'(k)});
      exp_q0.push_back(bcast({2'b00, 3'(k)}));
      tick();
      check($sformatf("solo valid c%0d", k), CDB_packet_out.valid, (k > 0));
      observe();
    end
    fu_valid = '0;
    check("solo ready0 end", fu_ready[0], 1'b1);
    repeat (3) begin
      tick();
      observe();
    end
    check("solo drained", exp_q0.size(), 0);

    // ---- fairness: FU0 and FU3 both kept non-empty ----
    squash_signal = 1'b1;
    tick();
    squash_signal = 1'b0;
    check("fair pre squash valid", CDB_packet_out.valid, 1'b0);
    fair_mode = 1'b1;
    last_fu   = -1;
    for (int k = 0; k < 12; k++) begin
      fu_valid = '0;
      if (fu_ready[0] === 1'b1) begin
        fu_valid[0]  = 1'b1;
        fu_packet[0] = mk_pkt({2'b00, 3'(k)});
        exp_q0.push_back(bcast({2'b00, 3'(k)}));
      end
      if (fu_ready[3] === 1'b1) begin
        fu_valid[3]  = 1'b1;
        fu_packet[3] = mk_pkt({2'b11, 3'(k)});
        exp_q3.push_back(bcast({2'b11, 3'(k)}));
      end
      tick();
      observe();
    end
    fu_valid = '0;
    repeat (6) begin
      tick();
      observe();
    end
    fair_mode = 1'b0;
    check("fair fu0 drained", exp_q0.size(), 0);
    check("fair fu3 drained", exp_q3.size(), 0);
    check("fair max wait within bound", (max_wait <= NUM_FU), 1'b1);
    check("fair pending idle", pending, 1'b0);

    // ---- asynchronous reset between edges ----
    fu_valid     = 4'b0101;
    fu_packet[0] = mk_pkt(5'd3);
    fu_packet[2] = mk_pkt(5'd17);
    tick();
    fu_valid = '0;
    tick();
    check("areset pre valid",   CDB_packet_out.valid, 1'b1);
    check("areset pre pending", pending, 1'b1);
    #3;
    reset = 1'b0;
    #1;
    $display("async reset asserted: valid=%b pending=%b ready=%b",
             CDB_packet_out.valid, pending, fu_ready);
    check("areset cdb zero", CDB_packet_out, '0);
    check("areset pending",  pending, 1'b0);
    check("areset ready",    fu_ready, 4'hF);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("post reset valid c%0d", k), CDB_packet_out.valid, 1'b0);
      check($sformatf("post reset pending c%0d", k), pending, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
